// File: rtl/pipeline_control.sv
// pipeline_control: central stall/flush controller for the 5-stage pipeline.
// Arbitrates load-use, multi-cycle EX and MEM exception requests.
module pipeline_control #(
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     id_stall_request,
  input  logic                     ex_start,
  input  logic                     ex_done,
  input  logic                     exception_request,
  input  logic [31:0]              exception_vector,
  input  logic                     stall_count_clear,
  output logic [5:0]               stall,
  output logic                     flush,
  output logic [31:0]              flush_pc,
  output logic                     busy,
  output logic [COUNTER_WIDTH-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN,
    EX_WAIT,
    FLUSH
  } state_t;

  localparam logic [5:0] STALL_ALL = 6'b111111;
  localparam logic [5:0] STALL_EX  = 6'b001111;
  localparam logic [5:0] STALL_ID  = 6'b000111;

  state_t     state;
  state_t     state_next;
  logic [5:0] stall_raw;
  logic       busy_raw;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Requests overlap freely, so arbitration is strictly ordered.
  always_comb begin
    state_next = state;
    stall_raw  = '0;
    busy_raw   = 1'b0;
    priority case (1'b1)
      exception_request: begin
        stall_raw  = STALL_ALL;
        state_next = FLUSH;
      end
      state == FLUSH: begin
        state_next = RUN;
      end
      state == EX_WAIT: begin
        if (ex_done) begin
          state_next = RUN;
        end else begin
          stall_raw = STALL_EX;
          busy_raw  = 1'b1;
        end
      end
      ex_start: begin
        if (!ex_done) begin
          stall_raw  = STALL_EX;
          busy_raw   = 1'b1;
          state_next = EX_WAIT;
        end
      end
      id_stall_request: begin
        stall_raw = STALL_ID;
      end
      default: begin
        stall_raw = '0;
      end
    endcase
  end

  assign stall = reset ? stall_raw : '0;
  assign busy  = reset ? busy_raw  : 1'b0;
  assign flush = (state == FLUSH);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flush_pc <= '0;
    end else if (exception_request) begin
      flush_pc <= exception_vector;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (stall_count_clear) begin
      stall_cycles <= '0;
    end else if ((|stall) && !(&stall_cycles)) begin
      stall_cycles <= stall_cycles + COUNTER_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_control.sv
// tb_pipeline_control: directed stimulus with a per-cycle reference model
// and literal checkpoints for pipeline_control (COUNTER_WIDTH=4).
module tb_pipeline_control;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        id_stall_request = 1'b0;
  logic        ex_start = 1'b0;
  logic        ex_done = 1'b0;
  logic        exception_request = 1'b0;
  logic [31:0] exception_vector = 32'h0;
  logic        stall_count_clear = 1'b0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        busy;
  logic [3:0]  stall_cycles;

  int total = 0;
  int bad = 0;

  logic        m_ex = 1'b0;
  logic        m_fl = 1'b0;
  logic [31:0] m_pc = 32'h0;
  int          m_cnt = 0;
  logic [6:0]  upd_o;
  logic [6:0]  cmp_o;

  pipeline_control #(.COUNTER_WIDTH(4)) dut (
    .clock             (clock),
    .reset             (reset),
    .id_stall_request  (id_stall_request),
    .ex_start          (ex_start),
    .ex_done           (ex_done),
    .exception_request (exception_request),
    .exception_vector  (exception_vector),
    .stall_count_clear (stall_count_clear),
    .stall             (stall),
    .flush             (flush),
    .flush_pc          (flush_pc),
    .busy              (busy),
    .stall_cycles      (stall_cycles)
  );

  always #5 clock = ~clock;

  // Returns {busy, stall} the pipeline must see this cycle.
  function automatic logic [6:0] model_out();
    if (!reset)                  return 7'h00;
    if (exception_request)       return {1'b0, 6'h3f};
    if (m_fl)                    return 7'h00;
    if (m_ex || ex_start) begin
      if (ex_done)               return 7'h00;
      return {1'b1, 6'h0f};
    end
    if (id_stall_request)        return {1'b0, 6'h07};
    return 7'h00;
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_ex  <= 1'b0;
      m_fl  <= 1'b0;
      m_pc  <= 32'h0;
      m_cnt <= 0;
    end else begin
      upd_o = model_out();
      if (stall_count_clear) m_cnt <= 0;
      else if (upd_o[5:0] != 6'h0) m_cnt <= (m_cnt < 15) ? m_cnt + 1 : 15;
      if (exception_request) m_pc <= exception_vector;
      m_ex <= !exception_request && !m_fl && (m_ex || ex_start) && !ex_done;
      m_fl <= exception_request;
    end
  end

  always @(negedge clock) begin
    cmp_o = model_out();
    check("m_stall", 32'(stall), 32'(cmp_o[5:0]));
    check("m_busy", 32'(busy), 32'(cmp_o[6]));
    check("m_flush", 32'(flush), 32'(m_fl));
    check("m_flush_pc", flush_pc, m_pc);
    check("m_stall_cycles", 32'(stall_cycles), 32'(m_cnt));
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic look();
    #3;
  endtask

  initial begin
    #1 reset = 1'b0;
    #1;
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_flush", 32'(flush), 32'h0);
    cyc(); cyc();
    reset = 1'b1;
    cyc(); look();
    check("idle_stall", 32'(stall), 32'h0);

    cyc(); ex_start = 1'b1; look();
    check("pre_rst_busy", 32'(busy), 32'h1);
    cyc(); ex_start = 1'b0; look();
    check("pre_rst_stall", 32'(stall), 32'h0f);
    cyc(); reset = 1'b0; #1;
    check("midrst_stall", 32'(stall), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_flush", 32'(flush), 32'h0);
    check("midrst_cnt", 32'(stall_cycles), 32'h0);
    cyc(); reset = 1'b1; look();
    check("post_rst_stall", 32'(stall), 32'h0);

    cyc(); id_stall_request = 1'b1; look();
    check("lu1_stall", 32'(stall), 32'h07);
    cyc(); look();
    check("lu2_stall", 32'(stall), 32'h07);
    cyc(); id_stall_request = 1'b0; look();
    check("lu_end_stall", 32'(stall), 32'h0);
    check("lu_cnt", 32'(stall_cycles), 32'h2);

    cyc(); ex_start = 1'b1; look();
    check("mc0_stall", 32'(stall), 32'h0f);
    check("mc0_busy", 32'(busy), 32'h1);
    cyc(); ex_start = 1'b0; look();
    check("mc1_stall", 32'(stall), 32'h0f);
    cyc(); look();
    check("mc2_stall", 32'(stall), 32'h0f);
    check("mc2_busy", 32'(busy), 32'h1);
    cyc(); ex_done = 1'b1; look();
    check("mc3_stall", 32'(stall), 32'h0);
    check("mc3_busy", 32'(busy), 32'h0);
    cyc(); ex_done = 1'b0; id_stall_request = 1'b1; look();
    check("mc4_run", 32'(stall), 32'h07);
    cyc(); id_stall_request = 1'b0; ex_start = 1'b1; ex_done = 1'b1; look();
    check("one_cyc_stall", 32'(stall), 32'h0);
    check("one_cyc_busy", 32'(busy), 32'h0);
    cyc(); ex_start = 1'b0; ex_done = 1'b0; look();
    check("one_cyc_after", 32'(busy), 32'h0);

    cyc(); exception_request = 1'b1; exception_vector = 32'h180; look();
    check("exc_stall", 32'(stall), 32'h3f);
    check("exc_flush0", 32'(flush), 32'h0);
    cyc(); exception_request = 1'b0; exception_vector = 32'h0; look();
    check("exc_flush1", 32'(flush), 32'h1);
    check("exc_pc", flush_pc, 32'h180);
    check("exc_flush_stall", 32'(stall), 32'h0);
    cyc(); look();
    check("exc_flush_end", 32'(flush), 32'h0);
    check("exc_pc_hold", flush_pc, 32'h180);

    cyc(); ex_start = 1'b1; look();
    check("exw_busy", 32'(busy), 32'h1);
    cyc(); ex_start = 1'b0; exception_request = 1'b1;
    exception_vector = 32'h3000; look();
    check("exw_exc_stall", 32'(stall), 32'h3f);
    check("exw_exc_busy", 32'(busy), 32'h0);
    cyc(); exception_request = 1'b0; look();
    check("exw_flush", 32'(flush), 32'h1);
    check("exw_busy_drop", 32'(busy), 32'h0);
    cyc(); look();
    check("exw_run_stall", 32'(stall), 32'h0);
    check("exw_run_busy", 32'(busy), 32'h0);

    cyc(); exception_request = 1'b1; exception_vector = 32'h100;
    cyc(); exception_vector = 32'h200; look();
    check("b2b_flush1", 32'(flush), 32'h1);
    check("b2b_pc1", flush_pc, 32'h100);
    check("b2b_stall", 32'(stall), 32'h3f);
    cyc(); exception_request = 1'b0; look();
    check("b2b_flush2", 32'(flush), 32'h1);
    check("b2b_pc2", flush_pc, 32'h200);
    cyc(); look();
    check("b2b_end", 32'(flush), 32'h0);

    cyc(); id_stall_request = 1'b1;
    repeat (19) cyc();
    look();
    check("cnt_sat", 32'(stall_cycles), 32'hf);
    cyc(); stall_count_clear = 1'b1; look();
    check("cnt_pre_clr", 32'(stall_cycles), 32'hf);
    cyc(); stall_count_clear = 1'b0; look();
    check("cnt_clr", 32'(stall_cycles), 32'h0);
    cyc(); look();
    check("cnt_after_clr", 32'(stall_cycles), 32'h1);
    cyc(); id_stall_request = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
